// File: rtl/aes_scan_target.sv
// Scan-loaded toy cipher target: serial shift register, key/data capture
// on synchronized strobes, and an XOR/rotate round loop with busy/valid handshake.
module aes_scan_target #(
  parameter int KW      = 128,
  parameter int NROUNDS = 10
) (
  input  logic CLK,
  input  logic reset1,
  input  logic SCLK,
  input  logic SE,
  input  logic SI,
  input  logic EN,
  input  logic Krdy,
  input  logic Drdy,
  output logic SO,
  output logic BSY,
  output logic Dvld
);

  localparam int RCW = $clog2(NROUNDS + 1);
  localparam logic [RCW-1:0] RC_LAST = RCW'(NROUNDS - 1);
  localparam logic [RCW-1:0] RC_MAX  = RCW'(NROUNDS);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   sreg_q, sreg_d;
  logic [KW-1:0]   key_q, key_d;
  logic [KW-1:0]   data_q, data_d;
  logic [KW-1:0]   st_q, st_d;
  logic [RCW-1:0]  rc_q, rc_d;
  logic            kv_q, kv_d;

  // Bit order {SCLK, SE, SI, Krdy, Drdy}; SE/SI are levels, so only the
  // three strobes carry a history flop.
  logic [4:0] pins;
  logic [4:0] s1_q, s2_q;
  logic [2:0] hist_q;

  assign pins = {SCLK, SE, SI, Krdy, Drdy};

  logic sclk_rise, krdy_rise, drdy_rise, se_s, si_s, busy, accept;

  assign se_s      = s2_q[3];
  assign si_s      = s2_q[2];
  assign sclk_rise = s2_q[4] & ~hist_q[2];
  assign krdy_rise = s2_q[1] & ~hist_q[1];
  assign drdy_rise = s2_q[0] & ~hist_q[0];
  assign busy      = (state_q == LOAD) || (state_q == ROUND);
  assign accept    = EN && !busy;

  assign SO   = sreg_q[KW-1];
  assign BSY  = busy;
  assign Dvld = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    key_d   = key_q;
    kv_d    = kv_q;
    data_d  = data_q;
    st_d    = st_q;
    rc_d    = rc_q;

    // Result load in DONE takes priority over a coincident scan shift.
    if (state_q == DONE)
      sreg_d = st_q;
    else if (sclk_rise && se_s && accept)
      sreg_d = {sreg_q[KW-2:0], si_s};

    if (krdy_rise && accept) begin
      key_d = sreg_q;
      kv_d  = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (drdy_rise && accept && kv_q && !krdy_rise) begin
          data_d  = sreg_q;
          state_d = LOAD;
        end
      end
      LOAD: begin
        st_d    = data_q ^ key_q;
        rc_d    = '0;
        state_d = ROUND;
      end
      ROUND: begin
        st_d = {st_q[KW-2:0], st_q[KW-1]} ^ key_q;
        if (rc_q != RC_MAX) rc_d = rc_q + RCW'(1);
        if (rc_q == RC_LAST) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset1) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      key_q   <= '0;
      kv_q    <= 1'b0;
      data_q  <= '0;
      st_q    <= '0;
      rc_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      key_q   <= key_d;
      kv_q    <= kv_d;
      data_q  <= data_d;
      st_q    <= st_d;
      rc_q    <= rc_d;
      s1_q    <= pins;
      s2_q    <= s1_q;
      hist_q  <= {s2_q[4], s2_q[1], s2_q[0]};
    end
  end

endmodule
